// File: rtl/hps_button_debounce.sv
// Synchronises, debounces and normalises the board KEY inputs for the HPS button PIO.
// Also produces one-cycle press/release strobes for fabric logic.
module hps_button_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] buttons_raw,
    output logic [WIDTH-1:0] buttons_out,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse
);

    localparam int              CW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   TERM = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] POL = {WIDTH{ACTIVE_LOW}};

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] lvl;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_nxt;
    logic [WIDTH-1:0] counting;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] press_q;
    logic [WIDTH-1:0] release_q;
    logic [WIDTH-1:0] press_nxt;
    logic [WIDTH-1:0] release_nxt;
    logic [CW-1:0]    cnt     [WIDTH];
    logic [CW-1:0]    cnt_nxt [WIDTH];

    // Sync flops carry raw pin polarity, so they reset to the released pin level
    // and a reset never looks like a press.
    assign lvl = s2 ^ POL;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1        <= POL;
            s2        <= POL;
            stable    <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1        <= buttons_raw;
            s2        <= s1;
            stable    <= stable_nxt;
            press_q   <= press_nxt;
            release_q <= release_nxt;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    // Per bit: STABLE while lvl matches, COUNTING while it differs.
    always_comb begin
        stable_nxt = stable;
        counting   = lvl ^ stable;
        term       = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = '0;
            if (counting[i]) begin
                if (cnt[i] == TERM) begin
                    term[i]       = 1'b1;
                    stable_nxt[i] = lvl[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        press_nxt   = term & stable_nxt;
        release_nxt = term & ~stable_nxt;
    end

    assign buttons_out   = stable;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule

// File: tb/tb_hps_button_debounce.sv
// Directed vector bench for hps_button_debounce (DEBOUNCE_CYCLES=8).
// Table vectors drive inputs on the falling edge and check just after the rising edge.
module tb_hps_button_debounce;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] raw;
    logic [3:0] raw1;
    logic [3:0] out0, prs0, rel0;
    logic [3:0] out1, prs1, rel1;

    always #5 clk = ~clk;

    hps_button_debounce #(
        .WIDTH(4), .DEBOUNCE_CYCLES(8), .ACTIVE_LOW(1'b1)
    ) u_lo (
        .clk(clk), .reset(rst), .buttons_raw(raw),
        .buttons_out(out0), .press_pulse(prs0), .release_pulse(rel0)
    );

    hps_button_debounce #(
        .WIDTH(4), .DEBOUNCE_CYCLES(8), .ACTIVE_LOW(1'b0)
    ) u_hi (
        .clk(clk), .reset(rst), .buttons_raw(raw1),
        .buttons_out(out1), .press_pulse(prs1), .release_pulse(rel1)
    );

    typedef struct {
        logic       rst;
        logic [3:0] raw;
        logic [3:0] out;
        logic [3:0] prs;
        logic [3:0] rel;
    } vec_t;

    vec_t vecs[$];
    int   applied     = 0;
    int   miscompares = 0;

    task automatic push(input logic r, input logic [3:0] rw,
                        input logic [3:0] o, input logic [3:0] p,
                        input logic [3:0] l, input int n);
        vec_t v;
        v.rst = r;
        v.raw = rw;
        v.out = o;
        v.prs = p;
        v.rel = l;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic check(input string name,
                         input logic [3:0] ao, input logic [3:0] ap,
                         input logic [3:0] al, input logic [3:0] eo,
                         input logic [3:0] ep, input logic [3:0] el);
        applied++;
        if (ao !== eo || ap !== ep || al !== el) begin
            miscompares++;
            $display("FAIL %s: got out=%h press=%h release=%h, want out=%h press=%h release=%h",
                     name, ao, ap, al, eo, ep, el);
        end
    endtask

    initial begin
        rst  = 1'b1;
        raw  = 4'hF;
        raw1 = 4'h0;

        // reset, then idle with all keys released
        push(1, 4'hF, 4'h0, 4'h0, 4'h0, 2);
        push(0, 4'hF, 4'h0, 4'h0, 4'h0, 50);
        // key 0 press and release
        push(0, 4'hE, 4'h0, 4'h0, 4'h0, 9);
        push(0, 4'hE, 4'h1, 4'h1, 4'h0, 1);
        push(0, 4'hE, 4'h1, 4'h0, 4'h0, 5);
        push(0, 4'hF, 4'h1, 4'h0, 4'h0, 9);
        push(0, 4'hF, 4'h0, 4'h0, 4'h1, 1);
        push(0, 4'hF, 4'h0, 4'h0, 4'h0, 5);
        // key 1 low for 7 cycles: rejected
        push(0, 4'hD, 4'h0, 4'h0, 4'h0, 7);
        push(0, 4'hF, 4'h0, 4'h0, 4'h0, 20);
        // key 1 low for exactly 8 cycles: accepted, then released
        push(0, 4'hD, 4'h0, 4'h0, 4'h0, 8);
        push(0, 4'hF, 4'h0, 4'h0, 4'h0, 1);
        push(0, 4'hF, 4'h2, 4'h2, 4'h0, 1);
        push(0, 4'hF, 4'h2, 4'h0, 4'h0, 7);
        push(0, 4'hF, 4'h0, 4'h0, 4'h2, 1);
        push(0, 4'hF, 4'h0, 4'h0, 4'h0, 5);
        // key 1 toggling every 3 cycles
        for (int k = 0; k < 17; k++) begin
            push(0, 4'hD, 4'h0, 4'h0, 4'h0, 3);
            push(0, 4'hF, 4'h0, 4'h0, 4'h0, 3);
        end
        push(0, 4'hF, 4'h0, 4'h0, 4'h0, 10);
        // all keys together, release key 2 alone, then the rest
        push(0, 4'h0, 4'h0, 4'h0, 4'h0, 9);
        push(0, 4'h0, 4'hF, 4'hF, 4'h0, 1);
        push(0, 4'h0, 4'hF, 4'h0, 4'h0, 3);
        push(0, 4'h4, 4'hF, 4'h0, 4'h0, 9);
        push(0, 4'h4, 4'hB, 4'h0, 4'h4, 1);
        push(0, 4'h4, 4'hB, 4'h0, 4'h0, 3);
        push(0, 4'hF, 4'hB, 4'h0, 4'h0, 9);
        push(0, 4'hF, 4'h0, 4'h0, 4'hB, 1);
        push(0, 4'hF, 4'h0, 4'h0, 4'h0, 3);
        // key 3 held, reset at count 5, re-debounced afterwards
        push(0, 4'h7, 4'h0, 4'h0, 4'h0, 7);
        push(1, 4'h7, 4'h0, 4'h0, 4'h0, 2);
        push(0, 4'h7, 4'h0, 4'h0, 4'h0, 9);
        push(0, 4'h7, 4'h8, 4'h8, 4'h0, 1);
        push(0, 4'h7, 4'h8, 4'h0, 4'h0, 3);
        push(0, 4'hF, 4'h8, 4'h0, 4'h0, 9);
        push(0, 4'hF, 4'h0, 4'h0, 4'h8, 1);
        push(0, 4'hF, 4'h0, 4'h0, 4'h0, 3);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst;
            raw = vecs[i].raw;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), out0, prs0, rel0,
                  vecs[i].out, vecs[i].prs, vecs[i].rel);
        end

        // active-high instance idle at 0 throughout the table
        check("hi_idle", out1, prs1, rel1, 4'h0, 4'h0, 4'h0);

        // active-high press on bit 0 alongside an active-low press on bit 0
        @(negedge clk);
        raw1 = 4'h1;
        raw  = 4'hE;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("hi_press%0d", k), out1, prs1, rel1,
                  (k >= 9) ? 4'h1 : 4'h0, (k == 9) ? 4'h1 : 4'h0, 4'h0);
            check($sformatf("lo_press%0d", k), out0, prs0, rel0,
                  (k >= 9) ? 4'h1 : 4'h0, (k == 9) ? 4'h1 : 4'h0, 4'h0);
        end

        // reset clears outputs without waiting for a clock edge
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("hi_async_rst", out1, prs1, rel1, 4'h0, 4'h0, 4'h0);
        check("lo_async_rst", out0, prs0, rel0, 4'h0, 4'h0, 4'h0);
        @(negedge clk);
        rst  = 1'b0;
        raw  = 4'hF;
        raw1 = 4'h0;
        repeat (12) @(posedge clk);
        #1;
        check("hi_after_rst", out1, prs1, rel1, 4'h0, 4'h0, 4'h0);
        check("lo_after_rst", out0, prs0, rel0, 4'h0, 4'h0, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
